// File: rtl/npu_seq_scheduler.sv
// Queued PE-array sequencer: instructions enter a small FIFO and are issued back-to-back
// as CFG (lane mask), CLR (accumulator clear) or multi-cycle MAC/RELU runs.
module npu_seq_scheduler #(
    parameter int unsigned N               = 10,
    parameter int unsigned SEL_DEMUX_WIDTH = 6,
    parameter int unsigned SEL_MUX_A_WIDTH = 4,
    parameter int unsigned SEL_MUX_B_WIDTH = 5,
    parameter int unsigned LEN_W           = 6,
    parameter int unsigned FIFO_DEPTH      = 4,
    localparam int unsigned W_INSTR = 2 + LEN_W + SEL_DEMUX_WIDTH + SEL_MUX_A_WIDTH
                                      + SEL_MUX_B_WIDTH,
    localparam int unsigned LVL_W   = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       instr_valid,
    output logic                       instr_ready,
    input  logic [W_INSTR-1:0]         instr,
    input  logic                       flush,
    input  logic                       pe_stall,
    output logic [N-1:0]               pe_en,
    output logic [N-1:0]               pe_mode_sel,
    output logic [N-1:0]               pe_reg_reset,
    output logic [SEL_DEMUX_WIDTH-1:0] pe_demux_sel,
    output logic [SEL_MUX_A_WIDTH-1:0] pe_mux_a_sel,
    output logic [SEL_MUX_B_WIDTH-1:0] pe_mux_b_sel,
    output logic                       busy,
    output logic                       op_done,
    output logic [LVL_W-1:0]           fifo_level
);

    localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned MA_LSB  = SEL_MUX_B_WIDTH;
    localparam int unsigned DX_LSB  = MA_LSB + SEL_MUX_A_WIDTH;
    localparam int unsigned LEN_LSB = DX_LSB + SEL_DEMUX_WIDTH;
    localparam int unsigned OP_LSB  = LEN_LSB + LEN_W;

    localparam logic [1:0] OP_CFG  = 2'b00;
    localparam logic [1:0] OP_CLR  = 2'b01;
    localparam logic [1:0] OP_RELU = 2'b11;

    if (N > W_INSTR - 2) begin : g_bad_n
        $error("npu_seq_scheduler: lane mask does not fit the instruction payload");
    end
    if (FIFO_DEPTH < 2) begin : g_bad_depth
        $error("npu_seq_scheduler: FIFO_DEPTH must be at least 2");
    end

    typedef enum logic [1:0] {StIdle, StCfg, StClr, StRun} state_e;

    state_e                     state_q, state_d;
    logic [N-1:0]               mask_q, mask_d;
    logic [LEN_W-1:0]           len_q, len_d;
    logic [LEN_W-1:0]           step_q, step_d;
    logic [N-1:0]               en_q, en_d;
    logic [N-1:0]               mode_q, mode_d;
    logic [N-1:0]               rr_q, rr_d;
    logic [SEL_DEMUX_WIDTH-1:0] demux_q, demux_d;
    logic [SEL_MUX_A_WIDTH-1:0] muxa_q, muxa_d;
    logic [SEL_MUX_B_WIDTH-1:0] muxb_q, muxb_d;
    logic                       done_q, done_d;
    logic                       busy_q, busy_d;
    logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]           count_q, count_d;

    logic [W_INSTR-1:0] mem [FIFO_DEPTH];
    logic [W_INSTR-1:0] head;
    logic [1:0]         head_op;
    logic               full, empty, push, pop, fin;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full        = (count_q == LVL_W'(FIFO_DEPTH));
    assign empty       = (count_q == '0);
    assign instr_ready = !full && !flush;
    assign push        = instr_valid && instr_ready;
    assign head        = mem[rd_ptr_q];
    assign head_op     = head[OP_LSB +: 2];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= instr;
        end
    end

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        len_d   = len_q;
        step_d  = step_q;
        en_d    = '0;
        mode_d  = '0;
        rr_d    = '0;
        demux_d = '0;
        muxa_d  = '0;
        muxb_d  = '0;
        done_d  = 1'b0;
        pop     = 1'b0;
        fin     = 1'b0;

        unique case (state_q)
            StIdle: fin = 1'b1;
            StCfg, StClr: begin
                done_d = 1'b1;
                fin    = 1'b1;
            end
            StRun: begin
                en_d    = en_q;
                mode_d  = mode_q;
                demux_d = demux_q;
                muxa_d  = muxa_q;
                muxb_d  = muxb_q;
                if (!pe_stall) begin
                    if (step_q == len_q) begin
                        done_d = 1'b1;
                        fin    = 1'b1;
                    end else begin
                        step_d = step_q + LEN_W'(1);
                        muxb_d = muxb_q + SEL_MUX_B_WIDTH'(1);
                    end
                end
            end
            default: ;
        endcase

        // End of an op (or idle): chain straight into the next queued op, no bubble.
        if (fin) begin
            state_d = StIdle;
            en_d    = '0;
            mode_d  = '0;
            demux_d = '0;
            muxa_d  = '0;
            muxb_d  = '0;
            if (!empty) begin
                pop = 1'b1;
                case (head_op)
                    OP_CFG: begin
                        state_d = StCfg;
                        mask_d  = head[N-1:0];
                    end
                    OP_CLR: begin
                        state_d = StClr;
                        rr_d    = mask_q;
                    end
                    default: begin
                        state_d = StRun;
                        len_d   = head[LEN_LSB +: LEN_W];
                        step_d  = '0;
                        en_d    = mask_q;
                        mode_d  = (head_op == OP_RELU) ? mask_q : '0;
                        demux_d = head[DX_LSB +: SEL_DEMUX_WIDTH];
                        muxa_d  = head[MA_LSB +: SEL_MUX_A_WIDTH];
                        muxb_d  = head[SEL_MUX_B_WIDTH-1:0];
                    end
                endcase
            end
        end

        if (flush) begin
            state_d = StIdle;
            mask_d  = mask_q;
            pop     = 1'b0;
            en_d    = '0;
            mode_d  = '0;
            rr_d    = '0;
            demux_d = '0;
            muxa_d  = '0;
            muxb_d  = '0;
            done_d  = 1'b0;
        end

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            count_d = count_q + LVL_W'(push) - LVL_W'(pop);
        end
        busy_d = (state_d != StIdle) || (count_d != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            mask_q   <= '1;
            len_q    <= '0;
            step_q   <= '0;
            en_q     <= '0;
            mode_q   <= '0;
            rr_q     <= '0;
            demux_q  <= '0;
            muxa_q   <= '0;
            muxb_q   <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            mask_q   <= mask_d;
            len_q    <= len_d;
            step_q   <= step_d;
            en_q     <= en_d;
            mode_q   <= mode_d;
            rr_q     <= rr_d;
            demux_q  <= demux_d;
            muxa_q   <= muxa_d;
            muxb_q   <= muxb_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Stall gates lane enables combinationally so the PEs freeze in the same cycle.
    assign pe_en        = en_q & ~{N{pe_stall}};
    assign pe_mode_sel  = mode_q;
    assign pe_reg_reset = rr_q;
    assign pe_demux_sel = demux_q;
    assign pe_mux_a_sel = muxa_q;
    assign pe_mux_b_sel = muxb_q;
    assign op_done      = done_q;
    assign busy         = busy_q;
    assign fifo_level   = count_q;

endmodule

// File: tb/tb_npu_seq_scheduler.sv
// Directed bench for npu_seq_scheduler: per-cycle vector table plus hand-written
// sequences for FIFO back-pressure, flush and asynchronous reset.
module tb_npu_seq_scheduler;

    localparam logic [9:0] M    = 10'h155;
    localparam logic [9:0] ONES = 10'h3FF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [22:0] instr;
    logic        flush;
    logic        pe_stall;
    logic [9:0]  pe_en, pe_mode_sel, pe_reg_reset;
    logic [5:0]  pe_demux_sel;
    logic [3:0]  pe_mux_a_sel;
    logic [4:0]  pe_mux_b_sel;
    logic        busy, op_done;
    logic [2:0]  fifo_level;

    int total = 0;
    int bad   = 0;

    npu_seq_scheduler dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr        (instr),
        .flush        (flush),
        .pe_stall     (pe_stall),
        .pe_en        (pe_en),
        .pe_mode_sel  (pe_mode_sel),
        .pe_reg_reset (pe_reg_reset),
        .pe_demux_sel (pe_demux_sel),
        .pe_mux_a_sel (pe_mux_a_sel),
        .pe_mux_b_sel (pe_mux_b_sel),
        .busy         (busy),
        .op_done      (op_done),
        .fifo_level   (fifo_level)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid;
        logic [22:0] instr;
        logic        flush;
        logic        stall;
        logic [50:0] exp;
    } vec_t;

    function automatic logic [22:0] mk(input logic [1:0] op, input logic [5:0] len,
                                       input logic [5:0] dmx, input logic [3:0] ma,
                                       input logic [4:0] mb);
        return {op, len, dmx, ma, mb};
    endfunction

    function automatic logic [22:0] cfg(input logic [9:0] mask);
        return {2'b00, 11'd0, mask};
    endfunction

    // exp packing: {en, mode, rr, demux, mux_a, mux_b, done, busy, level, ready}
    function automatic vec_t v(input logic valid, input logic [22:0] ins, input logic fl,
                               input logic st, input logic [9:0] en, input logic [9:0] mode,
                               input logic [9:0] rr, input logic [5:0] dmx,
                               input logic [3:0] ma, input logic [4:0] mb, input logic done,
                               input logic bsy, input logic [2:0] lvl, input logic rdy);
        vec_t r;
        r.valid = valid;
        r.instr = ins;
        r.flush = fl;
        r.stall = st;
        r.exp   = {en, mode, rr, dmx, ma, mb, done, bsy, lvl, rdy};
        return r;
    endfunction

    function automatic logic [50:0] observe();
        return {pe_en, pe_mode_sel, pe_reg_reset, pe_demux_sel, pe_mux_a_sel, pe_mux_b_sel,
                op_done, busy, fifo_level, instr_ready};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic drive(input logic vl, input logic [22:0] ins, input logic fl,
                         input logic st);
        @(negedge clk);
        instr_valid = vl;
        instr       = ins;
        flush       = fl;
        pe_stall    = st;
        #1;
    endtask

    vec_t tbl[$];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lo;
        rst_n = 1'b0;
        instr_valid = 1'b0;
        instr = '0;
        flush = 1'b0;
        pe_stall = 1'b0;

        // Test 1 reset state
        repeat (2) @(negedge clk);
        #1;
        chk("reset_outputs_async", observe(), {30'd0, 6'd0, 4'd0, 5'd0, 1'b0, 1'b0, 3'd0, 1'b1});
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_idle", observe(), {30'd0, 6'd0, 4'd0, 5'd0, 1'b0, 1'b0, 3'd0, 1'b1});

        // Test 2: CFG 0x155 then MAC len=3 demux=5 mux_a=2 mux_b=30
        tbl.push_back(v(1, cfg(M),            0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1));
        tbl.push_back(v(1, mk(2, 3, 5, 2, 30), 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 1, 1));
        tbl.push_back(v(0, '0,                0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 1, 1));
        tbl.push_back(v(0, '0,                0, 0, M, 0, 0, 5, 2, 30, 1, 1, 0, 1));
        tbl.push_back(v(0, '0,                0, 0, M, 0, 0, 5, 2, 31, 0, 1, 0, 1));
        tbl.push_back(v(0, '0,                0, 0, M, 0, 0, 5, 2,  0, 0, 1, 0, 1));
        tbl.push_back(v(0, '0,                0, 0, M, 0, 0, 5, 2,  1, 0, 1, 0, 1));
        tbl.push_back(v(0, '0,                0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 1));
        tbl.push_back(v(0, '0,                0, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1));
        // Test 3: CLR then RELU len=0, stall during CLR must not matter
        tbl.push_back(v(1, mk(1, 0, 0, 0, 0), 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1));
        tbl.push_back(v(1, mk(3, 0, 7, 3, 4), 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 1, 1));
        tbl.push_back(v(0, '0,                0, 1, 0, 0, M, 0, 0,  0, 0, 1, 1, 1));
        tbl.push_back(v(0, '0,                0, 0, M, M, 0, 7, 3,  4, 1, 1, 0, 1));
        tbl.push_back(v(0, '0,                0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 1));
        // Test 5: MAC len=2, stall two cycles at step 1
        tbl.push_back(v(1, mk(2, 2, 1, 1, 10), 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1));
        tbl.push_back(v(0, '0,                0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 1, 1));
        tbl.push_back(v(0, '0,                0, 0, M, 0, 0, 1, 1, 10, 0, 1, 0, 1));
        tbl.push_back(v(0, '0,                0, 1, 0, 0, 0, 1, 1, 11, 0, 1, 0, 1));
        tbl.push_back(v(0, '0,                0, 1, 0, 0, 0, 1, 1, 11, 0, 1, 0, 1));
        tbl.push_back(v(0, '0,                0, 0, M, 0, 0, 1, 1, 11, 0, 1, 0, 1));
        tbl.push_back(v(0, '0,                0, 0, M, 0, 0, 1, 1, 12, 0, 1, 0, 1));
        tbl.push_back(v(0, '0,                0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 1));
        tbl.push_back(v(0, '0,                0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1));

        foreach (tbl[i]) begin
            drive(tbl[i].valid, tbl[i].instr, tbl[i].flush, tbl[i].stall);
            chk($sformatf("vec%0d", i), 64'(observe()), 64'(tbl[i].exp));
        end

        // Test 4: long MAC holds the FIFO, five more pushes with valid held
        drive(1, mk(2, 63, 2, 1, 0), 0, 0);
        chk("bp_first_ready", 64'(instr_ready), 64'(1));
        for (int k = 1; k <= 4; k++) begin
            drive(1, mk(1, 0, 0, 0, 0), 0, 0);
        end
        drive(1, mk(1, 0, 0, 0, 0), 0, 0);
        chk("bp_full_level", 64'(fifo_level), 64'(4));
        chk("bp_full_ready", 64'(instr_ready), 64'(0));
        lo = 0;
        while (!instr_ready && lo < 200) begin
            lo++;
            @(negedge clk);
            #1;
        end
        chk("bp_ready_low_cycles", 64'(lo), 64'(61));
        chk("bp_level_after_pop", 64'(fifo_level), 64'(3));
        chk("bp_clr_after_run", 64'(pe_reg_reset), 64'(M));
        chk("bp_done_after_run", 64'(op_done), 64'(1));
        drive(0, '0, 0, 0);
        lo = 0;
        while (busy && lo < 50) begin
            lo++;
            @(negedge clk);
            #1;
        end
        chk("bp_drain_idle", 64'(busy), 64'(0));

        // Test 6: flush at step 2 of len=7 with 3 queued
        drive(1, mk(2, 7, 3, 2, 0), 0, 0);
        drive(1, mk(1, 0, 0, 0, 0), 0, 0);
        drive(1, mk(1, 0, 0, 0, 0), 0, 0);
        drive(1, mk(1, 0, 0, 0, 0), 0, 0);
        drive(1, mk(1, 0, 0, 0, 0), 1, 0);
        chk("fl_step2_muxb", 64'(pe_mux_b_sel), 64'(2));
        chk("fl_level_before", 64'(fifo_level), 64'(3));
        chk("fl_ready_gated", 64'(instr_ready), 64'(0));
        drive(0, '0, 0, 0);
        chk("fl_after", 64'(observe()), 64'({30'd0, 6'd0, 4'd0, 5'd0, 1'b0, 1'b0, 3'd0, 1'b1}));
        drive(0, '0, 0, 0);
        chk("fl_no_done", 64'(op_done), 64'(0));
        // lane mask survives flush
        drive(1, mk(3, 0, 0, 0, 0), 0, 0);
        drive(0, '0, 0, 0);
        drive(0, '0, 0, 0);
        chk("fl_mask_kept_en", 64'(pe_en), 64'(M));
        chk("fl_mask_kept_mode", 64'(pe_mode_sel), 64'(M));

        // Async reset mid-RUN
        drive(1, mk(2, 7, 9, 4, 9), 0, 0);
        drive(0, '0, 0, 0);
        drive(0, '0, 0, 0);
        chk("rst_run_active", 64'(pe_en), 64'(M));
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_run", 64'(observe()), 64'({30'd0, 6'd0, 4'd0, 5'd0, 1'b0, 1'b0, 3'd0, 1'b1}));
        @(negedge clk);
        rst_n = 1'b1;
        // After reset the mask is all lanes again
        drive(1, mk(2, 0, 0, 0, 0), 0, 0);
        drive(0, '0, 0, 0);
        drive(0, '0, 0, 0);
        chk("rst_mask_ones", 64'(pe_en), 64'(ONES));
        drive(0, '0, 0, 0);
        chk("rst_final_done", 64'(op_done), 64'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
